// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-wide memory port between two requesters: port 0 (wasm ROM
// parser) and port 1 (cpu). Each port owns a single-entry posted-write buffer,
// so a one-cycle write pulse is absorbed without stalling the requester. A
// four-state FSM (IDLE / WRITE / READ / RESP) serialises traffic onto the
// memory with round-robin arbitration between the two ports.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   pN_addr / pN_data_in     port N address and write data
//   pN_read_en               port N read request (level, held until pN_ready)
//   pN_write_en              port N write request (one-cycle pulse)
//   pN_data_out              port N read data, holds until the next completion
//   pN_ready                 port N read complete (one-cycle pulse)
//   pN_overflow              sticky: a port N write was dropped
//   mem_addr / mem_data_in   memory address and write data
//   mem_read_en              memory read enable (level)
//   mem_write_en             memory write enable (one-cycle pulse)
//   mem_data_out / mem_ready memory read data and its valid strobe
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data_in,
  input  logic              p0_read_en,
  input  logic              p0_write_en,
  output logic [DATA_W-1:0] p0_data_out,
  output logic              p0_ready,
  output logic              p0_overflow,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data_in,
  input  logic              p1_read_en,
  input  logic              p1_write_en,
  output logic [DATA_W-1:0] p1_data_out,
  output logic              p1_ready,
  output logic              p1_overflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  // Requester signals gathered into port-indexed form.
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [1:0]        req_rd;
  logic [1:0]        req_wr;

  assign req_addr[0]  = p0_addr;
  assign req_addr[1]  = p1_addr;
  assign req_wdata[0] = p0_data_in;
  assign req_wdata[1] = p1_data_in;
  assign req_rd       = {p1_read_en, p0_read_en};
  assign req_wr       = {p1_write_en, p0_write_en};

  state_e            state_q, state_d;
  // Port owning the current transaction; in IDLE it is the port granted last,
  // which is exactly what the round-robin tie-break needs.
  logic              grant_q, grant_d;
  logic [1:0]        buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q [2], buf_addr_d [2];
  logic [DATA_W-1:0] buf_data_q [2], buf_data_d [2];
  logic [DATA_W-1:0] rdata_q [2], rdata_d [2];
  logic [1:0]        ovf_q, ovf_d;

  logic [1:0]        pend;
  logic [1:0]        drain;
  logic [1:0]        ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    rdata_d      = rdata_q;
    ovf_d        = ovf_q;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    ready        = '0;
    drain        = '0;

    // A buffered write always goes first. A read arriving together with a
    // write pulse is held back: the write lands in the buffer this cycle and
    // must reach memory before that read is issued.
    pend = buf_valid_q | (req_rd & ~req_wr);

    case (state_q)
      IDLE: begin
        // mem_ready still high from the previous read: wait until it drops.
        if (!mem_ready && (pend != 2'b00)) begin
          if (pend == 2'b11) grant_d = ~grant_q;
          else               grant_d = pend[1];
          state_d = buf_valid_q[grant_d] ? WRITE : READ;
        end
      end
      WRITE: begin
        mem_write_en   = 1'b1;
        mem_addr       = buf_addr_q[grant_q];
        mem_data_in    = buf_data_q[grant_q];
        drain[grant_q] = 1'b1;
        state_d        = IDLE;
      end
      READ: begin
        mem_read_en = 1'b1;
        mem_addr    = req_addr[grant_q];
        if (mem_ready) begin
          rdata_d[grant_q] = mem_data_out;
          state_d          = RESP;
        end
      end
      RESP: begin
        ready[grant_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Posted-write buffers. A pulse arriving while the entry drains refills it.
    for (int n = 0; n < 2; n++) begin
      if (drain[n]) buf_valid_d[n] = 1'b0;
      if (req_wr[n]) begin
        if (!buf_valid_q[n] || drain[n]) begin
          buf_valid_d[n] = 1'b1;
          buf_addr_d[n]  = req_addr[n];
          buf_data_d[n]  = req_wdata[n];
        end else begin
          ovf_d[n] = 1'b1;
        end
      end
    end
  end

  // NOTE: non-blocking assignments only, so every flop samples the values of
  // the previous cycle regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      buf_valid_q <= '0;
      ovf_q       <= '0;
      // NOTE: the payload arrays are reset as well; rdata must read 0 after
      // reset and clearing the buffers keeps the whole state deterministic.
      for (int n = 0; n < 2; n++) begin
        buf_addr_q[n] <= '0;
        buf_data_q[n] <= '0;
        rdata_q[n]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      rdata_q     <= rdata_d;
      ovf_q       <= ovf_d;
    end
  end

  assign p0_data_out = rdata_q[0];
  assign p1_data_out = rdata_q[1];
  assign p0_ready    = ready[0];
  assign p1_ready    = ready[1];
  assign p0_overflow = ovf_q[0];
  assign p1_overflow = ovf_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios for write timing, write-then-read ordering, round-robin
// alternation, overflow, extended mem_ready and mid-read reset, followed by
// randomized episodes scored against a transaction-level model: a golden byte
// image updated when a write is accepted, and a queue of accepted writes that
// the memory must see drained in order.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_rd;
  logic [1:0]        in_wr;
  logic [DATA_W-1:0] out_dout [2];
  logic [1:0]        out_rdy;
  logic [1:0]        out_ovf;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_ready;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_addr      (in_addr[0]),
    .p0_data_in   (in_data[0]),
    .p0_read_en   (in_rd[0]),
    .p0_write_en  (in_wr[0]),
    .p0_data_out  (out_dout[0]),
    .p0_ready     (out_rdy[0]),
    .p0_overflow  (out_ovf[0]),
    .p1_addr      (in_addr[1]),
    .p1_data_in   (in_data[1]),
    .p1_read_en   (in_rd[1]),
    .p1_write_en  (in_wr[1]),
    .p1_data_out  (out_dout[1]),
    .p1_ready     (out_rdy[1]),
    .p1_overflow  (out_ovf[1]),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .mem_ready    (mem_ready)
  );

  // ---------------------------------------------------------------------------
  // Memory model: 256 bytes, preset on reset, read latency mem_lat cycles of
  // mem_read_en, mem_ready then held for mem_hold extra cycles.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] init_byte(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction

  logic [7:0] mem [256];
  int         mem_lat  = 1;
  int         mem_hold = 0;
  int         lat_cnt;
  int         hold_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready    <= 1'b0;
      mem_data_out <= '0;
      lat_cnt      <= 0;
      hold_cnt     <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(8'(i));
    end else begin
      if (mem_write_en) mem[mem_addr[7:0]] <= mem_data_in;
      if (mem_ready) begin
        lat_cnt <= 0;
        if (hold_cnt == 0) mem_ready <= 1'b0;
        else               hold_cnt  <= hold_cnt - 1;
      end else if (mem_read_en) begin
        if (lat_cnt + 1 >= mem_lat) begin
          mem_ready    <= 1'b1;
          mem_data_out <= mem[mem_addr[7:0]];
          hold_cnt     <= mem_hold;
          lat_cnt      <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end else begin
        lat_cnt <= 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int n = 0; n < 2; n++) begin
      in_addr[n] = '0;
      in_data[n] = '0;
    end
    in_rd = '0;
    in_wr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model for the random episodes
  // ---------------------------------------------------------------------------
  typedef struct {
    int         port;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq [$];      // accepted writes not yet seen at the memory
  logic [7:0] gold [256];  // memory image as seen by the requesters
  bit   [1:0] rd_act;
  int         rd_wait [2];
  logic [7:0] rd_addr [2];
  bit   [1:0] exp_ovf;
  bit   [1:0] prev_rdy;

  task automatic model_reset();
    wq.delete();
    rd_act   = '0;
    exp_ovf  = '0;
    prev_rdy = '0;
    for (int i = 0; i < 256; i++) gold[i] = init_byte(8'(i));
  endtask

  // Port n uses addresses 16*n .. 16*n+15, so a drained write identifies its port.
  task automatic rand_cycle(input bit stim);
    bit drain;
    int cnt;
    int idx;
    tick();
    for (int n = 0; n < 2; n++) begin
      in_wr[n] = 1'b0;
      if (!rd_act[n]) in_addr[n] = {27'd0, 1'(n), 4'($urandom_range(15))};
      if (stim && !rd_act[n] && $urandom_range(3) == 0) begin
        in_wr[n]   = 1'b1;
        in_data[n] = 8'($urandom);
      end
      if (rd_act[n]) begin
        in_rd[n] = 1'b1;
      end else if (stim && $urandom_range(2) == 0) begin
        rd_act[n]  = 1'b1;
        rd_wait[n] = 0;
        rd_addr[n] = in_addr[n][7:0];
        in_rd[n]   = 1'b1;
      end else begin
        in_rd[n] = 1'b0;
      end
    end
    smp();
    check("rd_wr_exclusive", 32'(mem_read_en & mem_write_en), 32'd0);
    for (int n = 0; n < 2; n++) begin
      drain = mem_write_en && (mem_addr[31:4] == 28'(n));
      cnt = 0;
      idx = -1;
      foreach (wq[i]) begin
        if (wq[i].port == n) begin
          cnt++;
          if (idx < 0) idx = i;
        end
      end
      check($sformatf("p%0d_overflow", n), 32'(out_ovf[n]), 32'(exp_ovf[n]));
      if (out_rdy[n]) begin
        check($sformatf("p%0d_ready_expected", n), 32'(rd_act[n]), 32'd1);
        check($sformatf("p%0d_ready_width", n), 32'(prev_rdy[n]), 32'd0);
        if (rd_act[n])
          check($sformatf("p%0d_rdata@%0h", n, rd_addr[n]), 32'(out_dout[n]),
                32'(gold[rd_addr[n]]));
        rd_act[n] = 1'b0;
      end else if (rd_act[n]) begin
        rd_wait[n]++;
        if (rd_wait[n] > 100) begin
          check($sformatf("p%0d_read_timeout", n), 32'(rd_wait[n]), 32'd100);
          rd_act[n] = 1'b0;
        end
      end
      if (drain) begin
        check($sformatf("p%0d_drain_pending", n), 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          check($sformatf("p%0d_drain_addr", n), 32'(mem_addr[7:0]), 32'(wq[idx].a));
          check($sformatf("p%0d_drain_data", n), 32'(mem_data_in), 32'(wq[idx].d));
          wq.delete(idx);
        end
      end
      if (in_wr[n]) begin
        if (cnt == 0 || drain) begin
          wq.push_back('{port: n, a: in_addr[n][7:0], d: in_data[n]});
          gold[in_addr[n][7:0]] = in_data[n];
        end else begin
          exp_ovf[n] = 1'b1;
        end
      end
      prev_rdy[n] = out_rdy[n];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int   wc, rc, nw, nrd;
  bit   got;
  bit   prev_mr, prev_re;
  bit   [1:0] prev_r;
  int   seq [$];

  initial begin
    clear_inputs();

    // Reset state, sampled while reset is still asserted.
    smp();
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    check("rst_mem_read_en", 32'(mem_read_en), 32'd0);
    check("rst_mem_write_en", 32'(mem_write_en), 32'd0);
    check("rst_p0_data_out", 32'(out_dout[0]), 32'd0);
    check("rst_p1_data_out", 32'(out_dout[1]), 32'd0);
    check("rst_ready", 32'(out_rdy), 32'd0);
    check("rst_overflow", 32'(out_ovf), 32'd0);

    // A: p1 write pulse reaches memory exactly two cycles later.
    mem_lat = 1; mem_hold = 0;
    do_reset();
    tick(); in_wr[1] = 1'b1; in_addr[1] = 32'hAA; in_data[1] = 8'h05;
    smp();  check("A_we_t0", 32'(mem_write_en), 32'd0);
    tick(); in_wr[1] = 1'b0;
    smp();  check("A_we_t1", 32'(mem_write_en), 32'd0);
    tick();
    smp();  check("A_we_t2", 32'(mem_write_en), 32'd1);
            check("A_addr_t2", mem_addr, 32'hAA);
            check("A_data_t2", 32'(mem_data_in), 32'h05);
    tick();
    smp();  check("A_we_t3", 32'(mem_write_en), 32'd0);
            check("A_p1_overflow", 32'(out_ovf[1]), 32'd0);

    // B: write then read of the same address on p1.
    tick(); in_wr[1] = 1'b1; in_addr[1] = 32'hAB; in_data[1] = 8'h07;
    smp();
    tick(); in_wr[1] = 1'b0; in_rd[1] = 1'b1;
    wc = -1; rc = -1; got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      smp();
      if (mem_write_en && wc < 0) begin
        wc = c;
        check("B_write_addr", mem_addr, 32'hAB);
        check("B_write_data", 32'(mem_data_in), 32'h07);
      end
      if (mem_read_en && rc < 0) rc = c;
      if (out_rdy[1]) begin
        got = 1'b1;
        check("B_p1_rdata", 32'(out_dout[1]), 32'h07);
        break;
      end
      tick();
    end
    check("B_read_done", 32'(got), 32'd1);
    check("B_write_before_read", 32'(wc >= 0 && rc > wc), 32'd1);
    tick(); in_rd[1] = 1'b0;
    smp();  check("B_ready_one_cycle", 32'(out_rdy[1]), 32'd0);
            check("B_rdata_held", 32'(out_dout[1]), 32'h07);

    // C: both ports hold reads; completions must alternate p0, p1, ...
    do_reset();
    tick(); in_rd = 2'b11; in_addr[0] = 32'h03; in_addr[1] = 32'h13;
    seq.delete(); prev_r = '0;
    for (int c = 0; c < 60; c++) begin
      smp();
      for (int n = 0; n < 2; n++) begin
        if (out_rdy[n]) begin
          seq.push_back(n);
          check($sformatf("C_p%0d_ready_width", n), 32'(prev_r[n]), 32'd0);
          check($sformatf("C_p%0d_rdata", n), 32'(out_dout[n]),
                32'(init_byte(8'(n * 16 + 3))));
        end
      end
      prev_r = out_rdy;
      tick();
    end
    clear_inputs();
    check("C_enough_grants", 32'(seq.size() >= 8), 32'd1);
    foreach (seq[k]) check($sformatf("C_grant%0d", k), 32'(seq[k]), 32'(k % 2));

    // D: two p1 writes while a slow p0 read is in flight; the second is dropped.
    mem_lat = 4; mem_hold = 0;
    do_reset();
    tick(); in_rd[0] = 1'b1; in_addr[0] = 32'h04;
    nw = 0; got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      smp();
      if (c == 3) check("D_ovf_after_first", 32'(out_ovf[1]), 32'd0);
      if (c == 5) check("D_ovf_after_second", 32'(out_ovf[1]), 32'd1);
      if (mem_write_en) begin
        nw++;
        check("D_write_addr", mem_addr, 32'h1A);
        check("D_write_data", 32'(mem_data_in), 32'h11);
      end
      if (out_rdy[0]) begin
        got = 1'b1;
        check("D_p0_rdata", 32'(out_dout[0]), 32'(init_byte(8'h04)));
      end
      tick();
      in_wr[1] = 1'b0;
      if (got) in_rd[0] = 1'b0;
      if (c == 1) begin in_wr[1] = 1'b1; in_addr[1] = 32'h1A; in_data[1] = 8'h11; end
      if (c == 3) begin in_wr[1] = 1'b1; in_addr[1] = 32'h1B; in_data[1] = 8'h22; end
    end
    smp();
    check("D_p0_read_done", 32'(got), 32'd1);
    check("D_one_write", 32'(nw), 32'd1);
    check("D_ovf_sticky", 32'(out_ovf[1]), 32'd1);

    // E: mem_ready held two extra cycles; no new read until it drops.
    mem_lat = 1; mem_hold = 2;
    do_reset();
    tick(); in_rd[0] = 1'b1; in_addr[0] = 32'h05;
    nrd = 0; prev_mr = 1'b0; prev_re = 1'b0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (mem_read_en && !prev_re) check("E_issue_after_ready_low", 32'(prev_mr), 32'd0);
      prev_re = mem_read_en;
      prev_mr = mem_ready;
      if (out_rdy[0]) begin
        nrd++;
        if (nrd == 1) check("E_rdata_first", 32'(out_dout[0]), 32'(init_byte(8'h05)));
        if (nrd == 2) check("E_rdata_second", 32'(out_dout[0]), 32'(init_byte(8'h06)));
      end
      tick();
      if (nrd == 1) in_addr[0] = 32'h06;
      if (nrd >= 2) in_rd[0] = 1'b0;
    end
    check("E_two_reads", 32'(nrd), 32'd2);

    // F: asynchronous reset during READ, with a p1 write sitting in its buffer.
    mem_lat = 4; mem_hold = 0;
    do_reset();
    tick(); in_rd[0] = 1'b1; in_addr[0] = 32'h05;
    smp();
    tick();
    smp();  check("F_reading", 32'(mem_read_en), 32'd1);
    tick(); in_wr[1] = 1'b1; in_addr[1] = 32'h1C; in_data[1] = 8'h77;
    smp();
    tick(); in_wr[1] = 1'b0;
    smp();  check("F_still_reading", 32'(mem_read_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("F_rst_read_en", 32'(mem_read_en), 32'd0);
    check("F_rst_write_en", 32'(mem_write_en), 32'd0);
    check("F_rst_ready", 32'(out_rdy), 32'd0);
    check("F_rst_mem_addr", mem_addr, 32'd0);
    clear_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    mem_lat = 1;
    tick(); in_rd[0] = 1'b1; in_addr[0] = 32'h06;
    nw = 0; got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      smp();
      if (mem_write_en) nw++;
      if (out_rdy[0]) begin
        got = 1'b1;
        check("F_p0_rdata", 32'(out_dout[0]), 32'(init_byte(8'h06)));
      end
      tick();
      if (got) in_rd[0] = 1'b0;
    end
    check("F_read_after_reset", 32'(got), 32'd1);
    check("F_buffer_discarded", 32'(nw), 32'd0);
    check("F_overflow_clear", 32'(out_ovf), 32'd0);

    // Randomized episodes across memory latencies and ready hold times.
    for (int ep = 0; ep < 4; ep++) begin
      mem_lat  = 1 + ep;
      mem_hold = ep % 3;
      do_reset();
      model_reset();
      repeat (600) rand_cycle(1'b1);
      repeat (100) rand_cycle(1'b0);
      check($sformatf("ep%0d_writes_drained", ep), 32'(wq.size()), 32'd0);
      check($sformatf("ep%0d_reads_done", ep), 32'(rd_act), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single byte-wide memory between the wasm ROM parser (port 0) and the cpu (port 1). It accepts the cpu's one-cycle write pulses into per-port posted-write buffers and serialises all traffic onto one memory port with round-robin fairness. It preserves per-port write-then-read ordering. It sits between the requesters and the memory model, replacing their direct connection.

## Interface
- ADDR_W, 32, address width
- DATA_W, 8, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- pN_addr  in  ADDR_W  port N address (N = 0 parser, 1 cpu)
- pN_data_in  in  DATA_W  port N write data
- pN_read_en  in  1  port N read request, level
- pN_write_en  in  1  port N write request, one-cycle pulse
- pN_data_out  out  DATA_W  port N read data, valid while pN_ready
- pN_ready  out  1  port N read complete, one-cycle pulse
- pN_overflow  out  1  sticky: port N write dropped
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_read_en  out  1  memory read enable, level
- mem_write_en  out  1  memory write enable, one-cycle pulse
- mem_data_out  in  DATA_W  memory read data
- mem_ready  in  1  memory read data valid; may stay high while mem_read_en high

## Operation
- Per port: 1-entry posted-write buffer (addr, data, valid). A write pulse captures pN_addr/pN_data_in into the buffer.
- Pending item per port: the buffered write if valid; otherwise the read if pN_read_en is high. A port's read is never issued while its own write is buffered.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: if mem_ready is high, issue nothing. Otherwise pick a pending port:
  - If both ports are pending, grant the port not granted last.
  - Register the grant and go to WRITE (write pending) or READ.
- WRITE: mem_write_en=1 for exactly one cycle with the buffered addr/data; clear that buffer's valid; go to IDLE.
- READ: mem_read_en=1 with mem_addr = granted pN_addr, sampled every cycle. When mem_ready: latch mem_data_out into pN_data_out; go to RESP.
- RESP: pN_ready=1 for one cycle; mem_read_en=0; go to IDLE.
- If pN_read_en is still high after its pN_ready, it is a new read at the current pN_addr.
- pN_data_out holds its value until the next read completion on that port.
- Write pulse when the buffer is valid and not being drained this cycle: write dropped, pN_overflow set. The flag stays set until reset.
- Write pulse in the same cycle the buffer drains (WRITE state): the new write is accepted (drain-and-fill).
- Write pulse and read_en in the same cycle on one port: write buffered; read waits behind it.
- Reads are not forwarded from the posted buffer; ordering is guaranteed by draining first.
- Reset values:
  - All outputs 0, including pN_data_out.
  - Buffers invalid; state IDLE.
  - Last-grant = port 1, so port 0 wins the first tie.
- Reset asserted mid-operation: outputs drop to 0 immediately (asynchronously). The in-flight read and buffered writes are discarded; requesters must re-request.

## Timing
- Write pulse in cycle t (idle arbiter, other port quiet): buffer valid at t+1; mem_write_en high in cycle t+2.
- Read request in cycle t (IDLE, mem_ready low): mem_read_en high from t+1.
  - mem_ready at cycle r: pN_ready and pN_data_out valid in r+1; mem_read_en low in r+1.
  - Minimum turnaround with single-cycle memory: 3 cycles.
- Back-to-back transactions: at least one IDLE cycle between them. A new read is additionally held off until mem_ready is low.
- Arbitration decisions are made only in IDLE; a granted transaction is never preempted.

## Test plan
- Reset, then p1 write pulse (addr 0xAA, data 0x05) -> mem_write_en single pulse at t+2 with mem_addr 0xAA, mem_data_in 0x05; p1_overflow 0.
- p1 write (0xAB, 0x07) in cycle t, p1_read_en (addr 0xAB) in cycle t+1, memory returning its stored byte -> the write reaches memory before mem_read_en rises; p1_data_out 0x07 with a one-cycle p1_ready.
- p0 and p1 hold reads continuously, both starting the same cycle -> grants alternate p0, p1, p0, p1; neither port starves; each pN_ready is exactly one cycle wide.
- Two p1 write pulses 1 cycle apart while p0 read is in flight (memory ready latency 4) -> second write dropped, p1_overflow=1 and sticky; only the first write reaches memory.
- Memory holds mem_ready high 2 extra cycles after a read -> no new mem_read_en until mem_ready is low; the next read completes correctly.
- rst asserted during READ with mem_read_en high -> mem_read_en 0 within the same cycle, all pN_ready 0, buffers cleared; after release, a p0 read completes normally.
